jtag_chain1: RTL and testbench
==============================

Name: jtag_chain1

Overview:
- JTAG user data-register chain (ER1 chain) bridging a 36-bit serial command protocol to a DMA controller and an external ping-pong word buffer.
- Each shifted 36-bit word holds a 4-bit opcode and a 32-bit payload, and executes on update.
- Responses are returned in the next scan.
- Sits between the FPGA JTAG primitive (JCE1/JSHIFT/JUPDATE/JRTI1) and the DMA/buffer subsystem.

Parameters:
- BUF_ADDR_W, 8, ping-pong buffer word-address width.

Ports:
- JTCK, input, 1, sole clock; all inputs are synchronous to it.
- JRST, input, 1, synchronous active-high reset.
- JTDI, input, 1, serial data in.
- JCE1, input, 1, chain enable (capture/shift).
- JSHIFT, input, 1, shift-DR.
- JUPDATE, input, 1, update-DR pulse.
- JRTI1, input, 1, Run-Test-Idle for this chain.
- JTD1, output, 1, serial data out = sr[0].
- pp_dataOut, input, 32, buffer read data; valid 1 cycle after pp_address.
- pp_dataIn, output, 32, buffer write data.
- pp_address, output, BUF_ADDR_W, buffer word address.
- pp_writeEnable, output, 1, buffer write strobe.
- DMA_busy, input, 1, DMA engine busy.
- DMA_block_size_IN, input, 8, words moved by last DMA transfer.
- DMA_address, output, 32, bus start address.
- DMA_burst_size, output, 8, burst size register.
- DMA_byte_enable, output, 4, byte enables.
- DMA_start_write, output, 1, 1-cycle pulse: buffer -> bus.
- DMA_start_read, output, 1, 1-cycle pulse: bus -> buffer.

Behaviour:
- Shift register sr[35:0]:
  - Capture: when JCE1=1 and JSHIFT=0, sr <= {resp[31:0], status[3:0]}.
  - Shift: when JCE1=1 and JSHIFT=1, sr <= {JTDI, sr[35:1]}, LSB first.
  - status = {1'b0, err, pending, DMA_busy}.
- Update: on JUPDATE=1, opcode=sr[3:0] and payload=sr[35:4]. The command executes in the next cycle.
- Opcodes:
  - 0x0: nop.
  - 0x1: address <= payload.
  - 0x2: byte_enable <= payload[3:0].
  - 0x3: burst_size <= payload[7:0].
  - 0x4: resp <= address.
  - 0x5: resp <= {28'b0, byte_enable}.
  - 0x6: resp <= {24'b0, burst_size}.
  - 0x7: resp <= {23'b0, DMA_busy, DMA_block_size_IN}.
  - 0x8: buffer write. One cycle of pp_writeEnable=1, pp_address=wr_ptr, pp_dataIn=payload; then wr_ptr++ (wraps at 2^BUF_ADDR_W).
  - 0x9: buffer read. pp_address=rd_ptr; the next cycle resp <= pp_dataOut and rd_ptr++ (wraps).
  - 0xA: pending <= WRITE.
  - 0xC: pending <= READ.
  - Any other opcode: err <= 1, no other effect. err clears on the next valid opcode.
- DMA launch:
  - Start condition: pending != NONE and JRTI1=1 and DMA_busy=0.
  - Issue the matching start pulse for exactly 1 cycle, clear pending, and reset wr_ptr and rd_ptr to 0.
  - While DMA_busy=1 the request waits indefinitely.
  - A new 0xA/0xC while pending overwrites the pending request; last wins.
- Buffer access while DMA_busy=1 is still executed; software must avoid it.
- Simultaneous JUPDATE and capture cannot occur; if they do, update takes priority.
- Reset values:
  - sr=0, resp=0, address=0, byte_enable=4'hF, burst_size=0.
  - wr_ptr=rd_ptr=0, pending=NONE, err=0.
  - All strobes 0, JTD1=0.
- Reset mid-operation aborts any pending DMA request and any buffer access.
- DMA_address, DMA_burst_size and DMA_byte_enable continuously reflect their registers.

Decomposition:
- Shared package jtag_chain1_pkg: opcode constants, pending-state enum (NONE/WRITE/READ), status bit indices.
- One sub-module, jtag_chain1_shift, is natural: the 36-bit capture/shift register producing JTD1 and instruction fields.
- Command decode, registers and DMA/buffer control stay in the top.

Test Plan:
- Scan 36'h13, then 36'h4, then 36'h0 -> the last scan's shifted-out bits [35:4] equal 0x00000000. Then scan 36'h6 then 36'h0 -> shifted-out resp = 0x00000001. DMA_burst_size=1.
- Scan 36'h555555551 then 36'h4 then 36'h0 -> returned resp = 0x55555555. DMA_address=0x55555555.
- Scan 36'hABCDEF8, 36'h1ABCDEF8, 36'h2ABCDEF8 -> three pp_writeEnable pulses, at addresses 0,1,2 with data 0x00ABCDEF, 0x01ABCDEF, 0x02ABCDEF.
- With DMA_busy=1 and JRTI1=1, scan 36'hA -> no start pulse; status bit1=1 on the next capture. Drop DMA_busy -> exactly one DMA_start_write pulse; pointers return to 0.
- Scan 36'hC with DMA_busy=0 -> one DMA_start_read pulse. Set pp_dataOut=0xFFFFFFFF and scan 36'h9 then 36'h0 -> returned resp = 0xFFFFFFFF.
- Scan opcode 0xF -> status err=1 on the next capture. Assert JRST -> all registers back to reset values; pending cleared.

Source files
------------

// File: rtl/jtag_chain1_pkg.sv
// jtag_chain1 shared definitions: opcodes, pending-request
// encoding and capture status bit positions.
package jtag_chain1_pkg;

   localparam int SR_W = 36;

   localparam logic [3:0] OP_NOP    = 4'h0;
   localparam logic [3:0] OP_ADDR   = 4'h1;
   localparam logic [3:0] OP_BE     = 4'h2;
   localparam logic [3:0] OP_BURST  = 4'h3;
   localparam logic [3:0] OP_RADDR  = 4'h4;
   localparam logic [3:0] OP_RBE    = 4'h5;
   localparam logic [3:0] OP_RBURST = 4'h6;
   localparam logic [3:0] OP_RSTAT  = 4'h7;
   localparam logic [3:0] OP_BWR    = 4'h8;
   localparam logic [3:0] OP_BRD    = 4'h9;
   localparam logic [3:0] OP_DMAW   = 4'hA;
   localparam logic [3:0] OP_DMAR   = 4'hC;

   typedef enum logic [1:0] {
      PEND_NONE  = 2'd0,
      PEND_WRITE = 2'd1,
      PEND_READ  = 2'd2
   } pend_e;

   localparam int ST_BUSY = 0;
   localparam int ST_PEND = 1;
   localparam int ST_ERR  = 2;

   function automatic logic op_valid(input logic [3:0] op);
      return !(op == 4'hB || op == 4'hD || op == 4'hE || op == 4'hF);
   endfunction

endpackage

// File: rtl/jtag_chain1_shift.sv
// 36-bit capture/shift data register for the ER1 chain.
// An update cycle freezes the register so the command fields stay stable.
module jtag_chain1_shift
   import jtag_chain1_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            tdi_i,
   input  logic            ce_i,
   input  logic            shift_i,
   input  logic            upd_i,
   input  logic [SR_W-1:0] cap_i,
   output logic [SR_W-1:0] sr_o,
   output logic            tdo_o
);

   logic [SR_W-1:0] sr_q;
   logic [SR_W-1:0] sr_d;

   always_comb begin
      sr_d = sr_q;
      if (upd_i) begin
         sr_d = sr_q;
      end else if (ce_i && !shift_i) begin
         sr_d = cap_i;
      end else if (ce_i && shift_i) begin
         sr_d = {tdi_i, sr_q[SR_W-1:1]};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) sr_q <= '0;
      else       sr_q <= sr_d;
   end

   assign sr_o  = sr_q;
   assign tdo_o = sr_q[0];

endmodule

// File: rtl/jtag_chain1.sv
// ER1 user chain: decodes shifted 36-bit commands into DMA
// register writes, ping-pong buffer accesses and DMA launches.
module jtag_chain1
   import jtag_chain1_pkg::*;
#(
   parameter int BUF_ADDR_W = 8
) (
   input  logic                  JTCK,
   input  logic                  JRST,
   input  logic                  JTDI,
   input  logic                  JCE1,
   input  logic                  JSHIFT,
   input  logic                  JUPDATE,
   input  logic                  JRTI1,
   output logic                  JTD1,
   input  logic [31:0]           pp_dataOut,
   output logic [31:0]           pp_dataIn,
   output logic [BUF_ADDR_W-1:0] pp_address,
   output logic                  pp_writeEnable,
   input  logic                  DMA_busy,
   input  logic [7:0]            DMA_block_size_IN,
   output logic [31:0]           DMA_address,
   output logic [7:0]            DMA_burst_size,
   output logic [3:0]            DMA_byte_enable,
   output logic                  DMA_start_write,
   output logic                  DMA_start_read
);

   logic [SR_W-1:0]       sr;
   logic [SR_W-1:0]       cap;
   logic [3:0]            status;
   logic                  launch;

   logic                  vld_q, vld_d;
   logic [3:0]            op_q, op_d;
   logic [31:0]           pay_q, pay_d;
   logic [31:0]           resp_q, resp_d;
   logic [31:0]           addr_q, addr_d;
   logic [3:0]            be_q, be_d;
   logic [7:0]            burst_q, burst_d;
   logic [BUF_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [BUF_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic                  rdp_q, rdp_d;
   pend_e                 pend_q, pend_d;
   logic                  err_q, err_d;
   logic                  sw_q, sw_d;
   logic                  srd_q, srd_d;

   always_comb begin
      status          = '0;
      status[ST_BUSY] = DMA_busy;
      status[ST_PEND] = (pend_q != PEND_NONE);
      status[ST_ERR]  = err_q;
   end

   assign cap = {resp_q, status};

   jtag_chain1_shift u_shift (
      .clk_i   (JTCK),
      .rst_i   (JRST),
      .tdi_i   (JTDI),
      .ce_i    (JCE1),
      .shift_i (JSHIFT),
      .upd_i   (JUPDATE),
      .cap_i   (cap),
      .sr_o    (sr),
      .tdo_o   (JTD1)
   );

   assign launch = (pend_q != PEND_NONE) && JRTI1 && !DMA_busy;

   always_comb begin
      vld_d    = JUPDATE;
      op_d     = JUPDATE ? sr[3:0] : op_q;
      pay_d    = JUPDATE ? sr[SR_W-1:4] : pay_q;
      resp_d   = resp_q;
      addr_d   = addr_q;
      be_d     = be_q;
      burst_d  = burst_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      rdp_d    = 1'b0;
      pend_d   = pend_q;
      err_d    = err_q;
      sw_d     = 1'b0;
      srd_d    = 1'b0;

      // Launch is evaluated first so a same-cycle 0xA/0xC re-arms pending.
      if (launch) begin
         sw_d     = (pend_q == PEND_WRITE);
         srd_d    = (pend_q == PEND_READ);
         pend_d   = PEND_NONE;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end

      if (rdp_q) begin
         resp_d   = pp_dataOut;
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      if (vld_q) begin
         err_d = !op_valid(op_q);
         case (op_q)
            OP_ADDR:   addr_d   = pay_q;
            OP_BE:     be_d     = pay_q[3:0];
            OP_BURST:  burst_d  = pay_q[7:0];
            OP_RADDR:  resp_d   = addr_q;
            OP_RBE:    resp_d   = {28'b0, be_q};
            OP_RBURST: resp_d   = {24'b0, burst_q};
            OP_RSTAT:  resp_d   = {23'b0, DMA_busy, DMA_block_size_IN};
            OP_BWR:    wr_ptr_d = wr_ptr_q + 1'b1;
            OP_BRD:    rdp_d    = 1'b1;
            OP_DMAW:   pend_d   = PEND_WRITE;
            OP_DMAR:   pend_d   = PEND_READ;
            default:   ;
         endcase
      end
   end

   always_ff @(posedge JTCK) begin
      if (JRST) begin
         vld_q    <= 1'b0;
         op_q     <= '0;
         pay_q    <= '0;
         resp_q   <= '0;
         addr_q   <= '0;
         be_q     <= 4'hF;
         burst_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         rdp_q    <= 1'b0;
         pend_q   <= PEND_NONE;
         err_q    <= 1'b0;
         sw_q     <= 1'b0;
         srd_q    <= 1'b0;
      end else begin
         vld_q    <= vld_d;
         op_q     <= op_d;
         pay_q    <= pay_d;
         resp_q   <= resp_d;
         addr_q   <= addr_d;
         be_q     <= be_d;
         burst_q  <= burst_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         rdp_q    <= rdp_d;
         pend_q   <= pend_d;
         err_q    <= err_d;
         sw_q     <= sw_d;
         srd_q    <= srd_d;
      end
   end

   assign pp_writeEnable  = vld_q && (op_q == OP_BWR);
   assign pp_address      = (vld_q && (op_q == OP_BRD)) ? rd_ptr_q : wr_ptr_q;
   assign pp_dataIn       = pay_q;
   assign DMA_address     = addr_q;
   assign DMA_burst_size  = burst_q;
   assign DMA_byte_enable = be_q;
   assign DMA_start_write = sw_q;
   assign DMA_start_read  = srd_q;

endmodule

// File: tb/tb_jtag_chain1.sv
// Directed bench for jtag_chain1: full 36-bit scans with
// hand-computed responses, strobe logging and reset checks.
module tb_jtag_chain1;

   logic        JTCK = 1'b0;
   logic        JRST = 1'b1;
   logic        JTDI = 1'b0;
   logic        JCE1 = 1'b0;
   logic        JSHIFT = 1'b0;
   logic        JUPDATE = 1'b0;
   logic        JRTI1 = 1'b0;
   logic        JTD1;
   logic [31:0] pp_dataOut = 32'h0;
   logic [31:0] pp_dataIn;
   logic [7:0]  pp_address;
   logic        pp_writeEnable;
   logic        DMA_busy = 1'b0;
   logic [7:0]  DMA_block_size_IN = 8'h0;
   logic [31:0] DMA_address;
   logic [7:0]  DMA_burst_size;
   logic [3:0]  DMA_byte_enable;
   logic        DMA_start_write;
   logic        DMA_start_read;

   int n_checks = 0;
   int n_fail = 0;
   int we_cnt = 0;
   int sw_cnt = 0;
   int srd_cnt = 0;
   logic [7:0]  we_addr [0:15];
   logic [31:0] we_data [0:15];
   logic [35:0] so;

   jtag_chain1 #(.BUF_ADDR_W(8)) dut (
      .JTCK              (JTCK),
      .JRST              (JRST),
      .JTDI              (JTDI),
      .JCE1              (JCE1),
      .JSHIFT            (JSHIFT),
      .JUPDATE           (JUPDATE),
      .JRTI1             (JRTI1),
      .JTD1              (JTD1),
      .pp_dataOut        (pp_dataOut),
      .pp_dataIn         (pp_dataIn),
      .pp_address        (pp_address),
      .pp_writeEnable    (pp_writeEnable),
      .DMA_busy          (DMA_busy),
      .DMA_block_size_IN (DMA_block_size_IN),
      .DMA_address       (DMA_address),
      .DMA_burst_size    (DMA_burst_size),
      .DMA_byte_enable   (DMA_byte_enable),
      .DMA_start_write   (DMA_start_write),
      .DMA_start_read    (DMA_start_read)
   );

   always #5 JTCK = ~JTCK;

   always @(negedge JTCK) begin
      if (pp_writeEnable) begin
         if (we_cnt < 16) begin
            we_addr[we_cnt] = pp_address;
            we_data[we_cnt] = pp_dataIn;
         end
         we_cnt++;
      end
      if (DMA_start_write) sw_cnt++;
      if (DMA_start_read) srd_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic scan(input logic [35:0] din, output logic [35:0] dout);
      @(negedge JTCK);
      JCE1 = 1'b1;
      JSHIFT = 1'b0;
      @(negedge JTCK);
      JSHIFT = 1'b1;
      for (int i = 0; i < 36; i++) begin
         JTDI = din[i];
         dout[i] = JTD1;
         @(negedge JTCK);
      end
      JCE1 = 1'b0;
      JSHIFT = 1'b0;
      JUPDATE = 1'b1;
      @(negedge JTCK);
      JUPDATE = 1'b0;
      repeat (3) @(negedge JTCK);
   endtask

   initial begin
      repeat (3) @(negedge JTCK);
      JRST = 1'b0;
      @(negedge JTCK);
      chk("rst_jtd1", 64'(JTD1), 64'h0);
      chk("rst_be", 64'(DMA_byte_enable), 64'hF);
      chk("rst_addr", 64'(DMA_address), 64'h0);
      chk("rst_we", 64'(pp_writeEnable), 64'h0);

      scan(36'h13, so);
      scan(36'h4, so);
      scan(36'h0, so);
      chk("resp_addr0", 64'(so[35:4]), 64'h0);
      scan(36'h6, so);
      scan(36'h0, so);
      chk("resp_burst", 64'(so[35:4]), 64'h1);
      chk("burst_out", 64'(DMA_burst_size), 64'h1);

      scan(36'h555555551, so);
      scan(36'h4, so);
      scan(36'h0, so);
      chk("resp_addr55", 64'(so[35:4]), 64'h55555555);
      chk("addr_out", 64'(DMA_address), 64'h55555555);

      scan(36'h52, so);
      chk("be_out", 64'(DMA_byte_enable), 64'h5);
      scan(36'h5, so);
      scan(36'h0, so);
      chk("resp_be", 64'(so[35:4]), 64'h5);

      scan(36'hABCDEF8, so);
      scan(36'h1ABCDEF8, so);
      scan(36'h2ABCDEF8, so);
      chk("we_cnt3", 64'(we_cnt), 64'd3);
      chk("we_a0", 64'(we_addr[0]), 64'h0);
      chk("we_d0", 64'(we_data[0]), 64'h00ABCDEF);
      chk("we_a1", 64'(we_addr[1]), 64'h1);
      chk("we_d1", 64'(we_data[1]), 64'h01ABCDEF);
      chk("we_a2", 64'(we_addr[2]), 64'h2);
      chk("we_d2", 64'(we_data[2]), 64'h02ABCDEF);

      DMA_busy = 1'b1;
      JRTI1 = 1'b1;
      scan(36'hA, so);
      chk("busy_no_sw", 64'(sw_cnt), 64'd0);
      scan(36'h0, so);
      chk("st_pend", 64'(so[1]), 64'h1);
      chk("st_busy", 64'(so[0]), 64'h1);
      DMA_busy = 1'b0;
      repeat (4) @(negedge JTCK);
      chk("sw_once", 64'(sw_cnt), 64'd1);
      chk("srd_none", 64'(srd_cnt), 64'd0);
      scan(36'h123456788, so);
      chk("we_cnt4", 64'(we_cnt), 64'd4);
      chk("wr_ptr_reset", 64'(we_addr[3]), 64'h0);
      chk("we_d3", 64'(we_data[3]), 64'h12345678);

      scan(36'hC, so);
      chk("srd_once", 64'(srd_cnt), 64'd1);
      chk("sw_still1", 64'(sw_cnt), 64'd1);
      pp_dataOut = 32'hFFFFFFFF;
      scan(36'h9, so);
      scan(36'h0, so);
      chk("resp_rd", 64'(so[35:4]), 64'hFFFFFFFF);
      chk("st_nopend", 64'(so[1]), 64'h0);

      DMA_block_size_IN = 8'h3C;
      scan(36'h7, so);
      scan(36'h0, so);
      chk("resp_stat", 64'(so[35:4]), 64'h3C);

      scan(36'hF, so);
      scan(36'h0, so);
      chk("st_err", 64'(so[2]), 64'h1);
      scan(36'h0, so);
      chk("err_clr", 64'(so[2]), 64'h0);

      scan(36'hB, so);
      DMA_busy = 1'b1;
      scan(36'hA, so);
      @(negedge JTCK);
      JRST = 1'b1;
      repeat (2) @(negedge JTCK);
      JRST = 1'b0;
      DMA_busy = 1'b0;
      repeat (4) @(negedge JTCK);
      chk("rst_no_sw", 64'(sw_cnt), 64'd1);
      chk("rst2_addr", 64'(DMA_address), 64'h0);
      chk("rst2_burst", 64'(DMA_burst_size), 64'h0);
      chk("rst2_be", 64'(DMA_byte_enable), 64'hF);
      chk("rst2_jtd1", 64'(JTD1), 64'h0);
      scan(36'h0, so);
      chk("rst2_scan", 64'(so), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
